// File: rtl/frame_uart_sender_pkg.sv
// ---------------------------------------------------------------------------
// frame_uart_sender_pkg
// Shared project package for the framebuffer transmit, receive and write paths.
// Holds the framebuffer geometry widths, the sender FSM state encoding and
// the pixel-to-byte formatting helper.
// ---------------------------------------------------------------------------
package frame_uart_sender_pkg;

   localparam int ADDR_W = 15;  // framebuffer linear address width
   localparam int PIX_W  = 3;   // bits per pixel

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      LATCH = 2'd2,
      SEND  = 2'd3
   } sender_state_t;

   // The receive side extracts the pixel from bits [3:1] of each byte.
   function automatic logic [7:0] format_pixel(input logic [PIX_W-1:0] pix);
      return {4'b0000, pix, 1'b0};
   endfunction

endpackage

// File: rtl/frame_uart_sender_uart_tx_byte.sv
// ---------------------------------------------------------------------------
// uart_tx_byte
// Serialises one byte as 8N1: start bit (0), data bits 0..7 LSB first,
// stop bit (1), each held CLKS_PER_BIT clocks. The line idles high.
// Ports:
//   CLOCK_50  in   system clock
//   resetn    in   synchronous active-low reset (aborts any byte in flight)
//   tx_start  in   load tx_data and begin the start bit next cycle (ignored
//                  while a byte is in flight)
//   tx_data   in   byte to send
//   tx_line   out  registered serial line
//   tx_done   out  one-cycle pulse in the final clock of the stop bit
// ---------------------------------------------------------------------------
module uart_tx_byte #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx_line,
   output logic       tx_done
);

   localparam int                BAUD_W    = $clog2(CLKS_PER_BIT + 1);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0]        STOP_BIT  = 4'd9;

   logic              active;
   logic [3:0]        bit_cnt;   // bit currently on the line: 0 start, 1..8 data, 9 stop
   logic [BAUD_W-1:0] baud_cnt;
   logic [8:0]        shreg;     // remaining data bits followed by the stop bit
   logic              bit_end;

   assign bit_end = active && (baud_cnt == BAUD_LAST);
   assign tx_done = bit_end && (bit_cnt == STOP_BIT);

   // NOTE: sequential state is updated only with non-blocking assignments so
   // every register samples the pre-edge value of every other register.
   always_ff @(posedge CLOCK_50) begin
      // NOTE: reset is synchronous; only the control registers and the line
      // need a defined value, but the shifter is cleared too so a reset
      // leaves no stale data behind.
      if (!resetn) begin
         active   <= 1'b0;
         bit_cnt  <= '0;
         baud_cnt <= '0;
         shreg    <= '1;
         tx_line  <= 1'b1;
      end else if (!active) begin
         if (tx_start) begin
            active   <= 1'b1;
            tx_line  <= 1'b0;
            shreg    <= {1'b1, tx_data};
            bit_cnt  <= '0;
            baud_cnt <= '0;
         end
      end else if (bit_end) begin
         baud_cnt <= '0;
         if (bit_cnt == STOP_BIT) begin
            active  <= 1'b0;
            tx_line <= 1'b1;
         end else begin
            bit_cnt <= bit_cnt + 4'd1;
            tx_line <= shreg[0];
            shreg   <= {1'b1, shreg[8:1]};
         end
      end else begin
         baud_cnt <= baud_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/frame_uart_sender.sv
// ---------------------------------------------------------------------------
// frame_uart_sender
// Streams one whole framebuffer out over UART, one byte per pixel in
// ascending linear address order, on a single-cycle start request.
// Ports:
//   CLOCK_50       in   system clock
//   resetn         in   synchronous active-low reset (aborts a frame)
//   start          in   frame request, honoured only while not busy
//   mem_addr_read  out  framebuffer read address (row*FRAME_W+col)
//   mem_data_read  in   pixel for mem_addr_read, one cycle later
//   UART_TXD       out  8N1 serial output, idle high
//   busy           out  frame in progress
//   done           out  one-cycle pulse as the last stop bit completes
// ---------------------------------------------------------------------------
module frame_uart_sender
   import frame_uart_sender_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int FRAME_W      = 160,
   parameter int FRAME_H      = 200
) (
   input  logic              CLOCK_50,
   input  logic              resetn,
   input  logic              start,
   output logic [ADDR_W-1:0] mem_addr_read,
   input  logic [PIX_W-1:0]  mem_data_read,
   output logic              UART_TXD,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(FRAME_W * FRAME_H - 1);

   sender_state_t     state, state_next;
   logic [ADDR_W-1:0] pix_cnt;
   logic              tx_start;
   logic              tx_done;
   logic              last_pix;

   assign last_pix      = (pix_cnt == LAST_PIX);
   assign mem_addr_read = pix_cnt;
   assign busy          = (state != IDLE);

   always_ff @(posedge CLOCK_50) begin
      if (!resetn) state <= IDLE;
      else         state <= state_next;
   end

   // READ presents the address, LATCH sees the pixel and hands the byte to
   // the serialiser, so the start bit appears two cycles after acceptance and
   // the line rests high for two cycles between bytes.
   always_comb begin
      // NOTE: defaults first so no path leaves a combinational output
      // unassigned, which would otherwise infer a latch.
      state_next = state;
      tx_start   = 1'b0;
      unique case (state)
         IDLE:  if (start) state_next = READ;
         READ:  state_next = LATCH;
         LATCH: begin
            tx_start   = 1'b1;
            state_next = SEND;
         end
         SEND:  if (tx_done) state_next = last_pix ? IDLE : READ;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         pix_cnt <= '0;
         done    <= 1'b0;
      end else begin
         done <= (state == SEND) && tx_done && last_pix;
         if ((state == IDLE) && start)
            pix_cnt <= '0;
         else if ((state == SEND) && tx_done)
            pix_cnt <= pix_cnt + 1'b1;
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_tx (
      .CLOCK_50 (CLOCK_50),
      .resetn   (resetn),
      .tx_start (tx_start),
      .tx_data  (format_pixel(mem_data_read)),
      .tx_line  (UART_TXD),
      .tx_done  (tx_done)
   );

endmodule

// File: tb/tb_frame_uart_sender.sv
// ---------------------------------------------------------------------------
// tb_frame_uart_sender
// Reduced-size frames (4 clocks per bit, 4x2 pixels). The expected line,
// busy, done and address values for every cycle of a frame are computed from
// the frame timing arithmetic: after the accepting edge each byte occupies
// P = 10*N + 2 cycles, two idle-high cycles followed by ten N-cycle bits.
// ---------------------------------------------------------------------------
module tb_frame_uart_sender;
   import frame_uart_sender_pkg::*;

   localparam int N    = 4;
   localparam int W    = 4;
   localparam int H    = 2;
   localparam int NPIX = W * H;
   localparam int P    = 10 * N + 2;

   logic              clk = 1'b0;
   logic              resetn;
   logic              start;
   logic [ADDR_W-1:0] mem_addr_read;
   logic [PIX_W-1:0]  mem_data_read;
   logic              UART_TXD;
   logic              busy;
   logic              done;

   logic [PIX_W-1:0]  mem [NPIX];

   int tests = 0;
   int fails = 0;

   frame_uart_sender #(
      .CLKS_PER_BIT (N),
      .FRAME_W      (W),
      .FRAME_H      (H)
   ) dut (
      .CLOCK_50      (clk),
      .resetn        (resetn),
      .start         (start),
      .mem_addr_read (mem_addr_read),
      .mem_data_read (mem_data_read),
      .UART_TXD      (UART_TXD),
      .busy          (busy),
      .done          (done)
   );

   always #5 clk = ~clk;

   // Synchronous framebuffer: data valid one cycle after the address.
   always @(posedge clk) begin
      if (int'(mem_addr_read) < NPIX) mem_data_read <= mem[int'(mem_addr_read)];
      else                            mem_data_read <= '0;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      tests++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
   endtask

   // Expected line level t cycles after the accepting edge.
   function automatic logic exp_line(input int t);
      int j, r, b;
      logic [7:0] byte_v;
      if (t < 1) return 1'b1;
      j = (t - 1) / P;
      r = (t - 1) % P;
      if (j >= NPIX || r < 2) return 1'b1;
      b = (r - 2) / N;
      if (b == 0) return 1'b0;
      if (b == 9) return 1'b1;
      byte_v = {4'b0000, mem[j], 1'b0};
      return byte_v[b-1];
   endfunction

   task automatic fill(input bit rand_fill);
      for (int i = 0; i < NPIX; i++)
         mem[i] = rand_fill ? PIX_W'($urandom_range(0, 7)) : PIX_W'(i % 8);
   endtask

   // Called #1 after an edge. Unless chained, pulses start itself; then checks
   // every cycle of the frame through the done cycle (or until abort_at).
   task automatic check_frame(input bit rand_fill, input int mid_start,
                              input bit chain_next, input int abort_at,
                              input bit chained);
      fill(rand_fill);
      if (!chained) begin
         start = 1'b1;
         @(posedge clk); #1;
      end
      for (int t = 1; t <= NPIX * P + 1; t++) begin
         check($sformatf("line t=%0d", t), 32'(UART_TXD), 32'(exp_line(t)));
         check($sformatf("busy t=%0d", t), 32'(busy), 32'(t <= NPIX * P));
         check($sformatf("done t=%0d", t), 32'(done), 32'(t == NPIX * P + 1));
         if ((t - 1) % P == 0 && t <= NPIX * P)
            check($sformatf("addr t=%0d", t), 32'(mem_addr_read), 32'((t - 1) / P));
         if (t == abort_at) return;
         start = (t == mid_start) || (chain_next && t == NPIX * P + 1);
         @(posedge clk); #1;
      end
   endtask

   task automatic check_idle(input int cycles, input string tag);
      for (int i = 0; i < cycles; i++) begin
         check($sformatf("%s line", tag), 32'(UART_TXD), 32'(1));
         check($sformatf("%s busy", tag), 32'(busy), 32'(0));
         check($sformatf("%s done", tag), 32'(done), 32'(0));
         @(posedge clk); #1;
      end
   endtask

   initial begin
      resetn = 1'b0;
      start  = 1'b0;
      fill(1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("reset line", 32'(UART_TXD), 32'(1));
      check("reset busy", 32'(busy), 32'(0));
      check("reset done", 32'(done), 32'(0));
      check("reset addr", 32'(mem_addr_read), 32'(0));
      resetn = 1'b1;
      @(posedge clk); #1;
      check_idle(3, "pre-start");

      // Pixel i%8: bytes 0x00,0x02,...,0x0E.
      check_frame(1'b0, 0, 1'b0, 0, 1'b0);
      check_idle(5, "after frame 1");

      // Extra start 100 cycles in must be ignored.
      check_frame(1'b1, 100, 1'b0, 0, 1'b0);
      check_idle(5, "after frame 2");

      // Start in the done cycle launches the next frame back to back.
      check_frame(1'b1, 0, 1'b1, 0, 1'b0);
      check_frame(1'b1, 0, 1'b0, 0, 1'b1);
      check_idle(5, "after chained frame");

      // Reset during data bit 3 of byte 5.
      check_frame(1'b1, 0, 1'b0, 5 * P + 3 + 4 * N + 1, 1'b0);
      resetn = 1'b0;
      @(posedge clk); #1;
      check("abort line", 32'(UART_TXD), 32'(1));
      check("abort busy", 32'(busy), 32'(0));
      check("abort done", 32'(done), 32'(0));
      check("abort addr", 32'(mem_addr_read), 32'(0));
      resetn = 1'b1;
      check_idle(2 * P, "after abort");
      check_frame(1'b1, 0, 1'b0, 0, 1'b0);
      check_idle(5, "after restart");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/frame_uart_sender.md
FRAME_UART_SENDER -- requirements
Module: frame_uart_sender

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, SHALL set the CLOCK_50 cycles per UART bit (115200 baud).
REQ-002 Parameter FRAME_W, default 160, SHALL set the pixels per row.
REQ-003 Parameter FRAME_H, default 200, SHALL set the rows per frame.
REQ-004 CLOCK_50  in  1  system clock; all logic on its rising edge.
REQ-005 resetn  in  1  synchronous, active-low reset.
REQ-006 start  in  1  single-cycle request to transmit one full frame.
REQ-007 mem_addr_read  out  15  framebuffer read address, linear index row*FRAME_W+col.
REQ-008 mem_data_read  in  3  framebuffer pixel, valid exactly one cycle after mem_addr_read is presented.
REQ-009 UART_TXD  out  1  serial output, 8N1, idle high.
REQ-010 busy  out  1  high from start acceptance until the last stop bit completes.
REQ-011 done  out  1  one-cycle pulse when the last stop bit of the frame completes.

Function
REQ-012 FSM states SHALL be IDLE, READ, LATCH, SEND.
- IDLE->READ on start while busy=0.
- READ->LATCH after 1 cycle.
- LATCH->SEND after 1 cycle.
- SEND->READ on byte complete when pixels remain.
- SEND->IDLE on byte complete of the final pixel.
REQ-013 Pixel index SHALL be a 15-bit counter, cleared to 0 on start acceptance and incremented by 1 at each byte completion; mem_addr_read SHALL equal this counter.
REQ-014 In LATCH, the transmitted byte SHALL be {4'b0000, mem_data_read[2:0], 1'b0}, with the pixel in bits [3:1] to match the receive-side pixel field.
REQ-015 Each byte SHALL be sent as a start bit (0), data bits 0..7 LSB first, and a stop bit (1), each held exactly CLKS_PER_BIT cycles.
REQ-016 The first start bit SHALL begin 2 cycles after start is sampled high; UART_TXD SHALL stay high for exactly 2 cycles between each stop bit end and the next start bit.
REQ-017 A frame SHALL be exactly FRAME_W*FRAME_H bytes, indices 0..FRAME_W*FRAME_H-1 (31999 at the defaults), in ascending order with no skip or repeat.
REQ-018 start while busy=1 SHALL be ignored with no effect on the frame in progress.
REQ-019 done and busy=0 SHALL occur in the same cycle; start sampled in that cycle SHALL be accepted and begin a new frame.
REQ-020 UART_TXD SHALL be a registered output with no glitches.

Reset
REQ-021 While resetn=0: state=IDLE, UART_TXD=1, busy=0, done=0, mem_addr_read=0, pixel counter=0, bit counter=0, baud counter=0.
REQ-022 Reset mid-byte or mid-frame SHALL abort immediately; UART_TXD SHALL be high in the first cycle after resetn is sampled low, and no partial frame SHALL resume.

Structure
REQ-023 The state encoding, ADDR_W=15, and PIX_W=3 SHALL live in the shared project package, also used by the receive and write path.
REQ-024 One sub-module, uart_tx_byte, SHALL do the serialisation, with ports: CLOCK_50, resetn, tx_start, tx_data[7:0], tx_line, tx_done (1-cycle pulse at stop-bit end).
REQ-025 frame_uart_sender SHALL own the FSM, pixel counter, and byte formatting only.

Verification
REQ-026 CLKS_PER_BIT=4, FRAME_W=4, FRAME_H=2, memory holding pixel=i%8, start pulse -> 8 bytes 0x00,0x02,0x04,...,0x0E on UART_TXD; each byte 40 cycles; 2-cycle idle gaps; done pulses once; busy high throughout.
REQ-027 Default parameters, memory all 3'b111, start pulse -> 32000 bytes of 0x0E; last mem_addr_read=31999; done pulses after 32000*(10*434+2) cycles (±2).
REQ-028 start pulsed again 100 cycles into a frame -> byte sequence and done timing identical to REQ-026.
REQ-029 resetn low for 1 cycle during data bit 3 of byte 5 -> UART_TXD=1 next cycle, busy=0, no done; a following start restarts at address 0.
REQ-030 start asserted in the done cycle -> new frame's first start bit begins 2 cycles later; address returns to 0.
REQ-031 Receiver loopback: UART_TXD fed to the existing receiver at matching baud -> its outputData[3:1] reproduces every framebuffer pixel in order.
